pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_sequencer_rr_arbiter.sv | 32 +++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the multi-hart PC sequencer.
package pc_seq_pkg;

  typedef logic [31:0] pc_t;

  localparam int unsigned MAX_HART_W          = 3;
  localparam int unsigned INC_DEFAULT         = 4;
  localparam pc_t         TRAP_VECTOR_DEFAULT = 32'h0000_0100;

  // Fetch request payload as seen by the instruction-fetch port.
  typedef struct packed {
    logic                  valid;
    pc_t                   pc;
    logic [MAX_HART_W-1:0] hart;
  } fetch_req_t;

endpackage

// File: rtl/pc_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter
  import pc_seq_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_c,
  output logic [W-1:0] idx_c,
  output logic         any_c
);

  int unsigned cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!any_c && req[cand]) begin
        gnt_c[cand] = 1'b1;
        idx_c       = W'(cand);
        any_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-hart PC sequencer: one PC per hart, round-robin into a registered fetch slot.
// Define PC_MISALIGN_TRAP_EN to send misaligned redirects to TRAP_VECTOR with trap_pulse.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     NUM_HARTS    = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] HART_STRIDE  = XLEN'(32'h0000_1000),
  parameter logic [XLEN-1:0] INC          = XLEN'(INC_DEFAULT),
`ifdef PC_MISALIGN_TRAP_EN
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
`endif
  localparam int unsigned    HART_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [NUM_HARTS-1:0]      hart_en,
  input  logic                      redirect_valid,
  input  logic [HART_W-1:0]         redirect_hart,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      fetch_valid,
  input  logic                      fetch_ready,
  output logic [XLEN-1:0]           fetch_pc,
  output logic [HART_W-1:0]         fetch_hart,
`ifdef PC_MISALIGN_TRAP_EN
  output logic [NUM_HARTS-1:0]      trap_pulse,
`endif
  output logic [NUM_HARTS*XLEN-1:0] pc_vec
);

  logic [NUM_HARTS-1:0][XLEN-1:0] pc_q;
  logic [HART_W-1:0]              rr_ptr;
  logic [HART_W-1:0]              rr_next;
  logic [NUM_HARTS-1:0]           redir_hit;
  logic [NUM_HARTS-1:0]           eligible;
  logic [NUM_HARTS-1:0]           gnt;
  logic [HART_W-1:0]              sel;
  logic                           any_elig;
  logic                           slot_free;
  logic                           kill;
  logic                           load;
  logic [XLEN-1:0]                redir_tgt;

  // Out-of-range redirect_hart matches no hart and is therefore ignored.
  always_comb begin
    redir_hit = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      redir_hit[h] = redirect_valid && (redirect_hart == HART_W'(h));
    end
  end

  assign eligible = hart_en & ~redir_hit;

  rr_arbiter #(
    .N (NUM_HARTS),
    .W (HART_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .gnt_c (gnt),
    .idx_c (sel),
    .any_c (any_elig)
  );

  // A redirect to the slot's hart kills it, overriding both accept and reload.
  assign slot_free = !fetch_valid || fetch_ready;
  assign kill      = fetch_valid && redirect_valid && (redirect_hart == fetch_hart);
  assign load      = slot_free && !stall && any_elig && !kill;
  assign rr_next   = (sel == HART_W'(NUM_HARTS - 1)) ? '0 : HART_W'(sel + 1'b1);

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |redirect_pc[1:0];
  assign redir_tgt  = misaligned ? TRAP_VECTOR : {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_pulse <= '0;
    end else begin
      trap_pulse <= misaligned ? redir_hit : '0;
    end
  end
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign redir_tgt      = {redirect_pc[XLEN-1:2], 2'b00};
`endif

  // Per-hart PCs and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        pc_q[h] <= RESET_VECTOR + XLEN'(h) * HART_STRIDE;
      end
      rr_ptr <= '0;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (redir_hit[h]) begin
          pc_q[h] <= redir_tgt;
        end else if (load && gnt[h]) begin
          pc_q[h] <= pc_q[h] + INC;
        end
      end
      if (load) begin
        rr_ptr <= rr_next;
      end
    end
  end

  // Fetch slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      fetch_hart  <= '0;
    end else if (kill) begin
      fetch_valid <= 1'b0;
    end else if (load) begin
      fetch_valid <= 1'b1;
      fetch_pc    <= pc_q[sel];
      fetch_hart  <= sel;
    end else if (slot_free) begin
      fetch_valid <= 1'b0;
    end
  end

  assign pc_vec = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected accepts are queued, a negedge monitor checks them.
module tb_pc_sequencer;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] H1T = 32'h0000_0100;
`else
  localparam logic [31:0] H1T = 32'h0000_3000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  hart_en;
  logic        redirect_valid;
  logic        redirect_hart;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        fetch_hart;
  logic [63:0] pc_vec;
`ifdef PC_MISALIGN_TRAP_EN
  logic [1:0]  trap_pulse;
  logic [2:0]  trap_pulse3;
`endif

  logic        rv3;
  logic [1:0]  rh3;
  logic [31:0] rp3;
  logic        fv3;
  logic [31:0] fpc3;
  logic [1:0]  fh3;
  logic [95:0] pc_vec3;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .hart_en        (hart_en),
    .redirect_valid (redirect_valid),
    .redirect_hart  (redirect_hart),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_hart     (fetch_hart),
`ifdef PC_MISALIGN_TRAP_EN
    .trap_pulse     (trap_pulse),
`endif
    .pc_vec         (pc_vec)
  );

  // Three-hart instance gives redirect_hart room for an out-of-range value.
  pc_sequencer #(.NUM_HARTS(3)) u_dut3 (
    .clk            (clk),
    .reset          (reset),
    .stall          (1'b0),
    .hart_en        (3'b000),
    .redirect_valid (rv3),
    .redirect_hart  (rh3),
    .redirect_pc    (rp3),
    .fetch_valid    (fv3),
    .fetch_ready    (1'b1),
    .fetch_pc       (fpc3),
    .fetch_hart     (fh3),
`ifdef PC_MISALIGN_TRAP_EN
    .trap_pulse     (trap_pulse3),
`endif
    .pc_vec         (pc_vec3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic h, input logic [31:0] pc);
    exp_q.push_back({h, pc});
  endtask

  // Monitor: an accept happens at the next edge unless a redirect kills the slot.
  always @(negedge clk) begin
    if (!reset && fetch_valid && fetch_ready &&
        !(redirect_valid && redirect_hart == fetch_hart)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL accept: unexpected hart %0d pc %0h, nothing expected", fetch_hart, fetch_pc);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({fetch_hart, fetch_pc} !== e) begin
          errors++;
          $display("FAIL accept: got hart %0d pc %0h expected hart %0d pc %0h",
                   fetch_hart, fetch_pc, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; hart_en = 2'b11; fetch_ready = 1'b1;
    redirect_valid = 1'b0; redirect_hart = 1'b0; redirect_pc = '0;
    rv3 = 1'b0; rh3 = '0; rp3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(fetch_valid), 128'(0));
    chk("rst_pc", 128'(fetch_pc), 128'(0));
    chk("rst_hart", 128'(fetch_hart), 128'(0));
    chk("rst_pcvec", 128'(pc_vec), {64'd0, 32'h1000, 32'h0});

    // Round-robin streaming, then hold under backpressure.
    push(0, 32'h0000); push(1, 32'h1000); push(0, 32'h0004);
    push(1, 32'h1004); push(0, 32'h0008);
    push(1, 32'h1008); push(0, 32'h000C); push(1, 32'h100C);
    reset = 1'b0;
    repeat (6) step();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", 128'(fetch_valid), 128'(1));
      chk("hold_pc", 128'(fetch_pc), 128'(32'h1008));
      chk("hold_hart", 128'(fetch_hart), 128'(1));
      chk("hold_pcvec", 128'(pc_vec), {64'd0, 32'h100C, 32'h000C});
    end
    fetch_ready = 1'b1;
    repeat (3) step();

    // Redirect the slot's hart while it is being accepted: kill wins.
    chk("pre_kill_pc", 128'(fetch_pc), 128'(32'h0010));
    chk("pre_kill_hart", 128'(fetch_hart), 128'(0));
    push(1, 32'h1010); push(0, 32'h2000); push(1, 32'h1014);
    redirect_valid = 1'b1; redirect_hart = 1'b0; redirect_pc = 32'h2000;
    step();
    redirect_valid = 1'b0;
    chk("kill_valid", 128'(fetch_valid), 128'(0));
    chk("kill_pc0", 128'(pc_vec[31:0]), 128'(32'h2000));
    step();
    chk("after_kill_hart", 128'(fetch_hart), 128'(1));
    step();
    chk("redir_issue", 128'({fetch_valid, fetch_hart, fetch_pc}), 128'({1'b1, 1'b0, 32'h2000}));
    step();

    // Stall: last slot drains, nothing loads, redirect still lands.
    stall = 1'b1;
    step();
    chk("stall_valid0", 128'(fetch_valid), 128'(0));
    chk("stall_pcvec0", 128'(pc_vec), {64'd0, 32'h1018, 32'h2004});
    step();
    chk("stall_valid1", 128'(fetch_valid), 128'(0));
    chk("stall_pcvec1", 128'(pc_vec), {64'd0, 32'h1018, 32'h2004});
    redirect_valid = 1'b1; redirect_hart = 1'b1; redirect_pc = 32'h3002;
    step();
    redirect_valid = 1'b0;
    chk("stall_valid2", 128'(fetch_valid), 128'(0));
    chk("stall_redir", 128'(pc_vec), {64'd0, H1T, 32'h2004});
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_pulse_hi", 128'(trap_pulse), 128'(2'b10));
`endif
    step();
    chk("stall_valid3", 128'(fetch_valid), 128'(0));
    chk("stall_pcvec3", 128'(pc_vec), {64'd0, H1T, 32'h2004});
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_pulse_lo", 128'(trap_pulse), 128'(2'b00));
`endif
    step();
    chk("stall_valid4", 128'(fetch_valid), 128'(0));

    // Only hart 0 enabled: pointer wraps back to it every time.
    push(0, 32'h2004); push(0, 32'h2008); push(0, 32'h200C); push(0, 32'h2010);
    stall = 1'b0; hart_en = 2'b01;
    repeat (4) step();
    hart_en = 2'b00;
    step();
    chk("en_drain_valid", 128'(fetch_valid), 128'(0));
    chk("en_pcvec", 128'(pc_vec), {64'd0, H1T, 32'h2014});

    push(1, H1T); push(0, 32'h2014);
    hart_en = 2'b11;
    repeat (3) step();
    stall = 1'b1; fetch_ready = 1'b0;
    chk("pre_rst_slot", 128'({fetch_valid, fetch_hart, fetch_pc}), 128'({1'b1, 1'b1, H1T + 32'd4}));

    // Asynchronous reset mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 128'(fetch_valid), 128'(0));
    chk("async_rst_pc", 128'(fetch_pc), 128'(0));
    chk("async_rst_pcvec", 128'(pc_vec), {64'd0, 32'h1000, 32'h0});
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    // Out-of-range redirect_hart is ignored; in-range one applies.
    step();
    reset = 1'b0;
    chk("h3_rst_pcvec", 128'(pc_vec3), {32'd0, 32'h2000, 32'h1000, 32'h0});
    rv3 = 1'b1; rh3 = 2'd3; rp3 = 32'h4000;
    step();
    rv3 = 1'b0;
    chk("h3_oor_ignored", 128'(pc_vec3), {32'd0, 32'h2000, 32'h1000, 32'h0});
    rv3 = 1'b1; rh3 = 2'd2;
    step();
    rv3 = 1'b0;
    chk("h3_redir_h2", 128'(pc_vec3), {32'd0, 32'h4000, 32'h1000, 32'h0});
    chk("idle_pcvec", 128'(pc_vec), {64'd0, 32'h1000, 32'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
